// File: rtl/subsurf_pkg.sv
// -----------------------------------------------------------------------------
// subsurf_pkg
//   Definitions shared by the subdivision-surface blocks.
//   - LOADER_ADDR_WIDTH : default OBJ RAM word-address width
//   - RAM_WORDS         : OBJ RAM depth in 32-bit words
//   - loader_state_e    : obj_loader FSM state encoding
// -----------------------------------------------------------------------------
package subsurf_pkg;

   localparam int LOADER_ADDR_WIDTH = 9;
   localparam int RAM_WORDS         = 512;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      KICK = 3'd2,
      WAIT = 3'd3,
      ERR  = 3'd4
   } loader_state_e;

endpackage : subsurf_pkg

// File: rtl/obj_loader.sv
// -----------------------------------------------------------------------------
// obj_loader
//   Accepts a mesh as a stream of 32-bit words, writes it into the OBJ RAM
//   from address 0 upward, then starts the subdivision top and waits for it
//   to finish.
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     s_valid/s_data/
//     s_last/s_ready      : upstream word stream; a word moves on a cycle where
//                           s_valid and s_ready are both 1 (s_ready never
//                           depends on s_valid; s_data/s_last are ignored
//                           while s_ready is 0)
//     en/a/we/di          : registered OBJ RAM write port (idle = all zero)
//     sub_start/sub_busy  : start request / busy status of the subdivision top
//     busy/done/error     : loader status; done is a one-cycle pulse, error is
//                           sticky until rst
//     words_loaded        : words accepted for the current / last mesh
//     state_o             : FSM state, for debug observation
// -----------------------------------------------------------------------------
module obj_loader
   import subsurf_pkg::*;
#(
   parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH,
   parameter int MIN_WORDS  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [31:0]           s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  en,
   output logic [ADDR_WIDTH-1:0] a,
   output logic [3:0]            we,
   output logic [31:0]           di,
   output logic                  sub_start,
   input  logic                  sub_busy,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output loader_state_e         state_o
);

   localparam logic [ADDR_WIDTH:0]   MIN_CNT = (ADDR_WIDTH+1)'(MIN_WORDS);
   localparam logic [ADDR_WIDTH:0]   ONE_CNT = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_A  = '1;

   loader_state_e           state_q, state_d;
   logic [ADDR_WIDTH:0]     words_q, words_d;
   logic                    en_q, en_d;
   logic [ADDR_WIDTH-1:0]   a_q, a_d;
   logic [3:0]              we_q, we_d;
   logic [31:0]             di_q, di_d;
   logic                    sub_start_q, sub_start_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    hs;
   logic [ADDR_WIDTH:0]     base;
   logic [ADDR_WIDTH:0]     cnt_inc;

   assign s_ready = (state_q == IDLE) || (state_q == LOAD);
   assign hs      = s_valid && s_ready;

   // The first word of a mesh always lands at address 0, which also restarts
   // the count without a separate clear cycle.
   assign base    = (state_q == IDLE) ? '0 : words_q;
   assign cnt_inc = base + ONE_CNT;

   always_comb begin
      state_d     = state_q;
      words_d     = words_q;
      en_d        = 1'b0;
      a_d         = '0;
      we_d        = 4'h0;
      di_d        = '0;
      sub_start_d = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;

      case (state_q)
         IDLE, LOAD: begin
            if (hs) begin
               en_d    = 1'b1;
               we_d    = 4'hF;
               a_d     = base[ADDR_WIDTH-1:0];
               di_d    = s_data;
               words_d = cnt_inc;
               busy_d  = 1'b1;
               if (s_last) begin
                  if (cnt_inc >= MIN_CNT) begin
                     state_d = KICK;
                  end else begin
                     state_d = ERR;
                     error_d = 1'b1;
                     busy_d  = 1'b0;
                  end
               end else if (base[ADDR_WIDTH-1:0] == LAST_A) begin
                  // RAM is full and the mesh has not ended: keep the word,
                  // never wrap the address.
                  state_d = ERR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = LOAD;
               end
            end
         end

         KICK: begin
            // sub_start is registered, so it first rises the cycle after the
            // final write is on the RAM port. Only a busy seen while the
            // request is already visible counts as an acknowledge.
            sub_start_d = 1'b1;
            if (sub_start_q && sub_busy) begin
               sub_start_d = 1'b0;
               state_d     = WAIT;
            end
         end

         WAIT: begin
            if (!sub_busy) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         ERR: begin
            error_d = 1'b1;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         words_q     <= '0;
         en_q        <= 1'b0;
         a_q         <= '0;
         we_q        <= 4'h0;
         di_q        <= '0;
         sub_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         words_q     <= words_d;
         en_q        <= en_d;
         a_q         <= a_d;
         we_q        <= we_d;
         di_q        <= di_d;
         sub_start_q <= sub_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign en           = en_q;
   assign a            = a_q;
   assign we           = we_q;
   assign di           = di_q;
   assign sub_start    = sub_start_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;
   assign state_o      = state_q;

endmodule : obj_loader
